// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Regenerates SD (27 MHz) output timing for the HDMI encoder. Internal
//   pixel/line counters free-run over the NTSC or PAL raster and snap to the
//   first active pixel on a vreset pulse from the video analyzer. All outputs
//   are registered and lag the internal counters by exactly one clock.
//
// Ports
//   clk          pixel clock
//   resetn       synchronous active-low reset
//   mode[1:0]    0=ntsc, 1=pal, 2=mono, 3=reserved (2 and 3 run PAL timing)
//   vreset       1-cycle resync request at the source's first active pixel
//   hs, vs       active-low syncs (vs is line-aligned)
//   de           high inside the active area
//   hcnt, vcnt   pixel/line index, 0 = first active pixel/line
//   frame_start  1-cycle pulse at pixel (0,0)
//   locked       last vreset found the counters already aligned
//   resync_cnt   saturating count of misaligned vreset events
module video_timing_gen #(
  parameter int H_ACT   = 720,
  parameter int H_TOT_N = 858,
  parameter int H_TOT_P = 864,
  parameter int H_SS_N  = 736,
  parameter int H_SS_P  = 732,
  parameter int H_SW_N  = 62,
  parameter int H_SW_P  = 64,
  parameter int V_ACT_N = 480,
  parameter int V_ACT_P = 576,
  parameter int V_TOT_N = 525,
  parameter int V_TOT_P = 625,
  parameter int V_SS_N  = 489,
  parameter int V_SS_P  = 581,
  parameter int V_SW_N  = 6,
  parameter int V_SW_P  = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  mode,
  input  logic        vreset,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [10:0] hcnt,
  output logic [9:0]  vcnt,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  resync_cnt
);

  logic [10:0] h;
  logic [9:0]  v;
  logic        cur_pal;

  logic [10:0] h_tot, h_ss, h_sw;
  logic [9:0]  v_tot, v_act, v_ss, v_sw;
  logic        h_last, v_last, frame_last, mode_pal;

  // Timing set follows the latched standard, never the live mode input,
  // so a mid-frame mode change cannot strand the counters out of range.
  always_comb begin
    h_tot = cur_pal ? 11'(H_TOT_P) : 11'(H_TOT_N);
    h_ss  = cur_pal ? 11'(H_SS_P)  : 11'(H_SS_N);
    h_sw  = cur_pal ? 11'(H_SW_P)  : 11'(H_SW_N);
    v_tot = cur_pal ? 10'(V_TOT_P) : 10'(V_TOT_N);
    v_act = cur_pal ? 10'(V_ACT_P) : 10'(V_ACT_N);
    v_ss  = cur_pal ? 10'(V_SS_P)  : 10'(V_SS_N);
    v_sw  = cur_pal ? 10'(V_SW_P)  : 10'(V_SW_N);
  end

  assign mode_pal   = (mode != 2'd0);
  assign h_last     = (h == h_tot - 11'd1);
  assign v_last     = (v == v_tot - 10'd1);
  assign frame_last = h_last && v_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      h           <= '0;
      v           <= '0;
      cur_pal     <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      de          <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      resync_cnt  <= '0;
    end else begin
      hcnt        <= h;
      vcnt        <= v;
      de          <= (h < 11'(H_ACT)) && (v < v_act);
      hs          <= !((h >= h_ss) && (h < h_ss + h_sw));
      vs          <= !((v >= v_ss) && (v < v_ss + v_sw));
      frame_start <= (h == 11'd0) && (v == 10'd0);

      if (vreset) begin
        h       <= '0;
        v       <= '0;
        cur_pal <= mode_pal;
        // Aligned only if we were about to wrap anyway under the same
        // standard; a standard change is always a real jump.
        if (frame_last && (mode_pal == cur_pal)) begin
          locked <= 1'b1;
        end else begin
          locked <= 1'b0;
          if (resync_cnt != 8'hff) resync_cnt <= resync_cnt + 8'd1;
        end
      end else if (h_last) begin
        h <= '0;
        if (v_last) begin
          v       <= '0;
          cur_pal <= mode_pal;
        end else begin
          v <= v + 10'd1;
        end
      end else begin
        h <= h + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  // Instance 0: shrunken raster so whole frames fit in a short run.
  // Instance 1: default (real SD) raster, checked over its first lines.
  localparam int HACT[2]  = '{10, 720};
  localparam int HTOTN[2] = '{16, 858};
  localparam int HTOTP[2] = '{18, 864};
  localparam int HSSN[2]  = '{11, 736};
  localparam int HSSP[2]  = '{12, 732};
  localparam int HSWN[2]  = '{3, 62};
  localparam int HSWP[2]  = '{4, 64};
  localparam int VACTN[2] = '{6, 480};
  localparam int VACTP[2] = '{8, 576};
  localparam int VTOTN[2] = '{10, 525};
  localparam int VTOTP[2] = '{12, 625};
  localparam int VSSN[2]  = '{7, 489};
  localparam int VSSP[2]  = '{9, 581};
  localparam int VSWN[2]  = '{2, 6};
  localparam int VSWP[2]  = '{1, 5};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] mode = 2'd0;
  logic vreset = 1'b0;

  logic s_hs, s_vs, s_de, s_fs, s_locked;
  logic [10:0] s_hcnt;
  logic [9:0] s_vcnt;
  logic [7:0] s_rc;
  logic l_hs, l_vs, l_de, l_fs, l_locked;
  logic [10:0] l_hcnt;
  logic [9:0] l_vcnt;
  logic [7:0] l_rc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  video_timing_gen #(
    .H_ACT(10), .H_TOT_N(16), .H_TOT_P(18), .H_SS_N(11), .H_SS_P(12),
    .H_SW_N(3), .H_SW_P(4), .V_ACT_N(6), .V_ACT_P(8), .V_TOT_N(10),
    .V_TOT_P(12), .V_SS_N(7), .V_SS_P(9), .V_SW_N(2), .V_SW_P(1)
  ) dut_s (
    .clk(clk), .resetn(resetn), .mode(mode), .vreset(vreset),
    .hs(s_hs), .vs(s_vs), .de(s_de), .hcnt(s_hcnt), .vcnt(s_vcnt),
    .frame_start(s_fs), .locked(s_locked), .resync_cnt(s_rc)
  );

  video_timing_gen dut_l (
    .clk(clk), .resetn(resetn), .mode(mode), .vreset(vreset),
    .hs(l_hs), .vs(l_vs), .de(l_de), .hcnt(l_hcnt), .vcnt(l_vcnt),
    .frame_start(l_fs), .locked(l_locked), .resync_cnt(l_rc)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: position is a linear pixel index within the frame; h/v are
  // derived by division, outputs are those of the position one clock ago.
  int  m_pos[2];
  bit  m_pal[2];
  bit  m_lk[2];
  int  m_rc[2];
  bit  e_hs[2], e_vs[2], e_de[2], e_fs[2];
  int  e_hcnt[2], e_vcnt[2];
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_pos[k] = 0; m_pal[k] = 0; m_lk[k] = 0; m_rc[k] = 0;
        e_hs[k] = 1; e_vs[k] = 1; e_de[k] = 0; e_fs[k] = 0;
        e_hcnt[k] = 0; e_vcnt[k] = 0;
      end else begin
        int ht, vt, hh, vv, hss, hsw, vss, vsw, vact;
        bit new_pal;
        ht   = m_pal[k] ? HTOTP[k] : HTOTN[k];
        vt   = m_pal[k] ? VTOTP[k] : VTOTN[k];
        hss  = m_pal[k] ? HSSP[k]  : HSSN[k];
        hsw  = m_pal[k] ? HSWP[k]  : HSWN[k];
        vss  = m_pal[k] ? VSSP[k]  : VSSN[k];
        vsw  = m_pal[k] ? VSWP[k]  : VSWN[k];
        vact = m_pal[k] ? VACTP[k] : VACTN[k];
        hh = m_pos[k] % ht;
        vv = m_pos[k] / ht;
        e_hcnt[k] = hh;
        e_vcnt[k] = vv;
        e_de[k] = (hh < HACT[k]) && (vv < vact);
        e_hs[k] = !(hh >= hss && hh < hss + hsw);
        e_vs[k] = !(vv >= vss && vv < vss + vsw);
        e_fs[k] = (m_pos[k] == 0);
        new_pal = (mode != 2'd0);
        if (vreset) begin
          if (m_pos[k] == ht * vt - 1 && new_pal == m_pal[k]) m_lk[k] = 1;
          else begin
            m_lk[k] = 0;
            if (m_rc[k] < 255) m_rc[k]++;
          end
          m_pos[k] = 0;
          m_pal[k] = new_pal;
        end else if (m_pos[k] == ht * vt - 1) begin
          m_pos[k] = 0;
          m_pal[k] = new_pal;
        end else begin
          m_pos[k]++;
        end
      end
    end
    if (!resetn) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("s_hs", s_hs, e_hs[0]);     chk("s_vs", s_vs, e_vs[0]);
      chk("s_de", s_de, e_de[0]);     chk("s_fs", s_fs, e_fs[0]);
      chk("s_hcnt", s_hcnt, e_hcnt[0]); chk("s_vcnt", s_vcnt, e_vcnt[0]);
      chk("s_locked", s_locked, m_lk[0]); chk("s_rc", s_rc, m_rc[0]);
      chk("l_hs", l_hs, e_hs[1]);     chk("l_vs", l_vs, e_vs[1]);
      chk("l_de", l_de, e_de[1]);     chk("l_fs", l_fs, e_fs[1]);
      chk("l_hcnt", l_hcnt, e_hcnt[1]); chk("l_vcnt", l_vcnt, e_vcnt[1]);
      chk("l_locked", l_locked, m_lk[1]); chk("l_rc", l_rc, m_rc[1]);
    end
  end

  task automatic wait_fs_s(output int t);
    bit seen = 0;
    t = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (s_fs) begin seen = 1; t = cyc; end
    end
    if (!seen) chk("timeout_fs", 0, 1);
  endtask

  task automatic wait_s_pos(input int hh, input int vv);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (s_hcnt == hh && s_vcnt == vv) seen = 1;
    end
    if (!seen) chk("timeout_s_pos", 0, 1);
  endtask

  task automatic wait_l_hcnt(input int hh);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (l_hcnt == hh) seen = 1;
    end
    if (!seen) chk("timeout_l_hcnt", 0, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_hs", s_hs, 1);   chk("rst_s_vs", s_vs, 1);
    chk("rst_s_de", s_de, 0);   chk("rst_s_fs", s_fs, 0);
    chk("rst_s_hcnt", s_hcnt, 0); chk("rst_s_vcnt", s_vcnt, 0);
    chk("rst_s_locked", s_locked, 0); chk("rst_s_rc", s_rc, 0);
    chk("rst_l_hs", l_hs, 1);   chk("rst_l_de", l_de, 0);
    chk("rst_l_fs", l_fs, 0);   chk("rst_l_rc", l_rc, 0);
  endtask

  initial begin
    int t0, t1, t2, rc0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    resetn = 1'b1;

    // NTSC free-run on the small raster: 16*10 = 160 cycles per frame
    wait_fs_s(t0);
    wait_fs_s(t1);
    chk("ntsc_period", t1 - t0, 160);

    // Real-raster horizontal pins: de ends at 720, hs low 736..797
    wait_l_hcnt(719); chk("l_de_719", l_de, 1);
    @(negedge clk);   chk("l_de_720", l_de, 0);
    wait_l_hcnt(735); chk("l_hs_735", l_hs, 1);
    @(negedge clk);   chk("l_hs_736", l_hs, 0);
    wait_l_hcnt(797); chk("l_hs_797", l_hs, 0);
    @(negedge clk);   chk("l_hs_798", l_hs, 1);

    // Mid-frame switch to PAL: current frame stays NTSC, next is 18*12=216
    wait_fs_s(t0);
    repeat (5) @(negedge clk);
    mode = 2'd1;
    wait_fs_s(t1);
    chk("switch_ntsc_len", t1 - t0, 160);
    wait_fs_s(t2);
    chk("switch_pal_len", t2 - t1, 216);

    // Misaligned vreset at h=100 on the real raster
    mode = 2'd0;
    wait_l_hcnt(99);
    vreset = 1'b1;
    @(negedge clk);
    vreset = 1'b0;
    chk("vr_hcnt_lag", l_hcnt, 100);
    @(negedge clk);
    chk("vr_hcnt0", l_hcnt, 0);
    chk("vr_vcnt0", l_vcnt, 0);
    chk("vr_fs", l_fs, 1);
    chk("vr_locked", l_locked, 0);
    chk("vr_rc", l_rc, 1);

    // Aligned vreset at the last pixel of the small NTSC frame
    wait_fs_s(t0);
    rc0 = m_rc[0];
    wait_s_pos(14, 9);
    vreset = 1'b1;
    @(negedge clk);
    vreset = 1'b0;
    chk("al_locked", s_locked, 1);
    chk("al_rc", s_rc, rc0);
    wait_fs_s(t1);
    chk("al_period", t1 - t0, 160);

    // Same spot, but with a standard change: must count as a jump
    rc0 = m_rc[0];
    wait_s_pos(14, 9);
    vreset = 1'b1;
    mode = 2'd1;
    @(negedge clk);
    vreset = 1'b0;
    chk("mc_locked", s_locked, 0);
    chk("mc_rc", s_rc, rc0 + 1);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      vreset = 1'b1;
      @(negedge clk);
      vreset = 1'b0;
      repeat (2) @(negedge clk);
    end
    chk("sat_s_rc", s_rc, 255);
    chk("sat_l_rc", l_rc, 255);

    // Reset beats a simultaneous vreset
    resetn = 1'b0;
    vreset = 1'b1;
    @(negedge clk);
    vreset = 1'b0;
    chk_reset_vals();
    @(negedge clk);

    // From reset with mode=1: first frame NTSC, then PAL
    resetn = 1'b1;
    wait_fs_s(t0);
    wait_fs_s(t1);
    wait_fs_s(t2);
    chk("pal_first_len", t1 - t0, 160);
    chk("pal_second_len", t2 - t1, 216);
    wait_s_pos(11, 0); chk("pal_hs_11", s_hs, 1);
    @(negedge clk);    chk("pal_hs_12", s_hs, 0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
